// File: rtl/type_param_rr_arb_if.sv
// Requester/consumer bundle for type_param_rr_arb; the payload type and requester
// count travel with the interface so both ends agree on widths.
interface type_param_rr_arb_if #(
  parameter int NREQ = 4,
  parameter type data_t = logic [7:0],
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) ();

  logic [NREQ-1:0]  req_valid;
  data_t            req_data [NREQ];
  logic [NREQ-1:0]  req_ready;
  logic             out_valid;
  data_t            out_data;
  logic [IDX_W-1:0] out_src;
  logic             out_ready;
  logic [15:0]      xfer_count;

  // Arbiter side
  modport master (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src, xfer_count
  );

  // Producer/consumer side
  modport slave (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src, xfer_count
  );

endinterface

// File: rtl/type_param_rr_arb.sv
// Round-robin arbiter sharing one registered valid/ready output between NREQ
// requesters, with the payload carried as a type parameter.
module type_param_rr_arb #(
  parameter int NREQ = 4,
  parameter type data_t = logic [7:0],
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input logic clk,
  input logic rst,
  type_param_rr_arb_if.master bus
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] src_q;
  data_t            data_q;
  logic [15:0]      xfer_q;

  logic [IDX_W:0]   idx;
  logic [IDX_W-1:0] grant;
  logic             hit;
  logic             canLoad;
  logic             load;
  logic             handshake;

  // Scan from the highest offset down so the requester nearest ptr wins
  always_comb begin
    idx   = '0;
    grant = '0;
    hit   = 1'b0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = {1'b0, ptr_q} + (IDX_W+1)'(off);
      if (idx >= (IDX_W+1)'(NREQ)) begin
        idx = idx - (IDX_W+1)'(NREQ);
      end
      if (bus.req_valid[idx[IDX_W-1:0]]) begin
        hit   = 1'b1;
        grant = idx[IDX_W-1:0];
      end
    end
  end

  assign canLoad   = (state_q == IDLE) || bus.out_ready;
  assign load      = canLoad && hit;
  assign handshake = (state_q == HOLD) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = HOLD;
    end else if (handshake) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (load && !rst) begin
      bus.req_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = (grant == IDX_W'(NREQ - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      src_q  <= '0;
      data_q <= '0;
      xfer_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (load) begin
        src_q  <= grant;
        data_q <= bus.req_data[grant];
      end
      if (handshake) begin
        xfer_q <= xfer_q + 16'd1;
      end
    end
  end

  assign bus.out_valid  = (state_q == HOLD);
  assign bus.out_data   = data_q;
  assign bus.out_src    = src_q;
  assign bus.xfer_count = xfer_q;

endmodule

// File: tb/tb_type_param_rr_arb.sv
// Directed bench for type_param_rr_arb: a 4-requester byte instance plus a sweep of
// 3-requester instances with payload widths 1..8.
module tb_type_param_rr_arb;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  type_param_rr_arb_if #(.NREQ(4), .data_t(logic [7:0])) bus ();

  type_param_rr_arb #(.NREQ(4), .data_t(logic [7:0])) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic       sweepRst;
  logic [2:0] sweepValid;
  logic       sweepReady;
  logic [1:0] sweepSrc  [1:8];
  logic [7:0] sweepData [1:8];
  int         sweepBits [1:8];

  // One 3-requester instance per payload width; requester i offers i+1
  for (genvar m = 1; m <= 8; m++) begin : g_sweep
    typedef logic [m-1:0] sw_t;
    type_param_rr_arb_if #(.NREQ(3), .data_t(sw_t)) sbus ();
    type_param_rr_arb #(.NREQ(3), .data_t(sw_t)) u_sdut (
      .clk (clk),
      .rst (sweepRst),
      .bus (sbus)
    );
    assign sbus.req_valid = sweepValid;
    assign sbus.out_ready = sweepReady;
    for (genvar i = 0; i < 3; i++) begin : g_data
      assign sbus.req_data[i] = sw_t'(i + 1);
    end
    assign sweepSrc[m]  = sbus.out_src;
    assign sweepData[m] = 8'(sbus.out_data);
    assign sweepBits[m] = $bits(sbus.out_data);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rstVal, input logic [3:0] validVal,
                               input logic readyVal);
    rst           = rstVal;
    bus.req_valid = validVal;
    bus.out_ready = readyVal;
    #1;
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    sweepRst   = 1'b1;
    sweepValid = 3'b000;
    sweepReady = 1'b0;
    for (int i = 0; i < 4; i++) bus.req_data[i] = 8'(8'h10 + i);

    // Reset held two cycles with every requester asserting
    applyStimulus(1'b1, 4'hF, 1'b0);
    checkOutput("rst_req_ready_comb", 32'(bus.req_ready), 32'h0);
    waitCycle();
    waitCycle();
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("rst_xfer", 32'(bus.xfer_count), 32'h0);
    checkOutput("rst_out_src", 32'(bus.out_src), 32'h0);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'h0);

    // Single request from requester 2
    bus.req_data[2] = 8'hA5;
    applyStimulus(1'b0, 4'b0100, 1'b1);
    checkOutput("single_req_ready", 32'(bus.req_ready), 32'h4);
    waitCycle();
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("single_out_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("single_out_data", 32'(bus.out_data), 32'hA5);
    checkOutput("single_out_src", 32'(bus.out_src), 32'h2);
    checkOutput("single_req_ready_idle", 32'(bus.req_ready), 32'h0);
    waitCycle();
    checkOutput("single_drain_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("single_xfer", 32'(bus.xfer_count), 32'h1);

    // Fairness from a fresh pointer with everybody requesting
    applyStimulus(1'b1, 4'h0, 1'b1);
    waitCycle();
    applyStimulus(1'b0, 4'hF, 1'b1);
    checkOutput("fair_first_ready", 32'(bus.req_ready), 32'h1);
    for (int k = 0; k < 8; k++) begin
      waitCycle();
      checkOutput($sformatf("fair_src_%0d", k), 32'(bus.out_src), 32'(k % 4));
      checkOutput($sformatf("fair_valid_%0d", k), 32'(bus.out_valid), 32'h1);
      checkOutput($sformatf("fair_ready_%0d", k), 32'(bus.req_ready),
                  32'(1 << ((k + 1) % 4)));
    end
    waitCycle();
    checkOutput("fair_xfer_8", 32'(bus.xfer_count), 32'd8);
    checkOutput("fair_wrap_src", 32'(bus.out_src), 32'h0);

    // Backpressure while holding requester 1
    waitCycle();
    checkOutput("bp_hold_src", 32'(bus.out_src), 32'h1);
    applyStimulus(1'b0, 4'hF, 1'b0);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("bp_ready_%0d", k), 32'(bus.req_ready), 32'h0);
      waitCycle();
      checkOutput($sformatf("bp_src_%0d", k), 32'(bus.out_src), 32'h1);
      checkOutput($sformatf("bp_data_%0d", k), 32'(bus.out_data), 32'h11);
      checkOutput($sformatf("bp_valid_%0d", k), 32'(bus.out_valid), 32'h1);
    end
    checkOutput("bp_xfer_frozen", 32'(bus.xfer_count), 32'd9);
    applyStimulus(1'b0, 4'hF, 1'b1);
    checkOutput("bp_release_ready", 32'(bus.req_ready), 32'h4);
    waitCycle();
    checkOutput("bp_release_src", 32'(bus.out_src), 32'h2);
    checkOutput("bp_release_data", 32'(bus.out_data), 32'hA5);
    checkOutput("bp_release_xfer", 32'(bus.xfer_count), 32'd10);

    // Reset in the middle of a held item
    applyStimulus(1'b1, 4'hF, 1'b1);
    checkOutput("midrst_req_ready", 32'(bus.req_ready), 32'h0);
    waitCycle();
    applyStimulus(1'b0, 4'hF, 1'b1);
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("midrst_xfer", 32'(bus.xfer_count), 32'h0);
    checkOutput("midrst_ready", 32'(bus.req_ready), 32'h1);
    waitCycle();
    checkOutput("midrst_src", 32'(bus.out_src), 32'h0);
    checkOutput("midrst_valid", 32'(bus.out_valid), 32'h1);

    // Width sweep, all three requesters asserting, pointer wraps 2 -> 0
    for (int m = 1; m <= 8; m++) begin
      checkOutput($sformatf("sweep_bits_m%0d", m), 32'(sweepBits[m]), 32'(m));
    end
    waitCycle();
    sweepRst   = 1'b0;
    sweepValid = 3'b111;
    sweepReady = 1'b1;
    for (int step = 0; step < 4; step++) begin
      waitCycle();
      for (int m = 1; m <= 8; m++) begin
        checkOutput($sformatf("sweep_src_m%0d_s%0d", m, step), 32'(sweepSrc[m]),
                    32'(step % 3));
        checkOutput($sformatf("sweep_data_m%0d_s%0d", m, step), 32'(sweepData[m]),
                    32'(((step % 3) + 1) % (1 << m)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
